// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//  Shared definitions for the load/store unit:
//   - lsu_type_e  : access size encoding driven by the execute stage
//   - lsu_state_e : handshake FSM states of lsu_obi_ctrl
//   - lsu_misaligned() : alignment rule applied when a request is accepted
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10,
        LSU_RSVD = 2'b11
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10,
        RESP        = 2'b11
    } lsu_state_e;

    // The reserved size code is reported the same way as a misaligned access,
    // so the core sees a single error class for "cannot be issued".
    function automatic logic lsu_misaligned(input lsu_type_e typ, input logic [1:0] offset);
        logic mis;
        case (typ)
            LSU_BYTE: mis = 1'b0;
            LSU_HALF: mis = offset[0];
            LSU_WORD: mis = (offset != 2'b00);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// ----------------------------------------------------------------------------
// lsu_data_align (combinational)
//  Lane handling for the load/store unit.
//  Ports:
//   type_i     : access size (lsu_type_e)
//   offset_i   : byte offset inside the word (addr[1:0])
//   sign_ext_i : 1 = sign-extend load result, 0 = zero-extend
//   wdata_i    : LSB-justified store data
//   rdata_i    : raw 32-bit word from the bus
//   be_o       : byte enables for the bus
//   wdata_o    : store data moved to its byte lane
//   rdata_o    : load data moved down to bit 0 and extended
// ----------------------------------------------------------------------------
module lsu_data_align
    import lsu_pkg::*;
(
    input  lsu_type_e   type_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shift_amt;
    logic [31:0] rdata_shifted;

    always_comb begin
        shift_amt     = {offset_i, 3'b000};
        wdata_o       = wdata_i << shift_amt;
        rdata_shifted = rdata_i >> shift_amt;

        case (type_i)
            LSU_BYTE: be_o = 4'b0001 << offset_i;
            LSU_HALF: be_o = 4'b0011 << offset_i;
            LSU_WORD: be_o = 4'b1111;
            default:  be_o = 4'b0000;
        endcase

        case (type_i)
            LSU_BYTE: rdata_o = {{24{sign_ext_i & rdata_shifted[7]}},  rdata_shifted[7:0]};
            LSU_HALF: rdata_o = {{16{sign_ext_i & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default:  rdata_o = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_obi_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_obi_ctrl
//  Load/store unit between the execute stage and the OBI data port. Accepts a
//  single access in IDLE, runs req/gnt/rvalid, and returns formatted load data.
//  Ports:
//   clk_i, rst_ni        : clock (rising edge), async active-low reset
//   i_lsu_*              : core request (req, we, type, sign_ext, addr, wdata)
//   o_lsu_busy           : core stall, accept cycle through done cycle
//   o_lsu_done/o_lsu_err : one-cycle completion pulse and its error flag
//   o_lsu_rdata          : registered load result, only updated by good loads
//   data_*               : OBI master port
//  Parameter RVALID_TIMEOUT : wait-state cycles before abort, 0 disables it
// ----------------------------------------------------------------------------
module lsu_obi_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned RVALID_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_lsu_req,
    input  logic        i_lsu_we,
    input  logic [1:0]  i_lsu_type,
    input  logic        i_lsu_sign_ext,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_busy,
    output logic        o_lsu_done,
    output logic        o_lsu_err,
    output logic [31:0] o_lsu_rdata,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o
);

    localparam int unsigned WD_W = (RVALID_TIMEOUT > 1) ? $clog2(RVALID_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RVALID_TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    lsu_type_e   type_q, type_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic        wd_expire;
    logic [3:0]  be_aligned;
    logic [31:0] wdata_aligned;
    logic [31:0] rdata_fmt;

    lsu_data_align u_align (
        .type_i     (type_q),
        .offset_i   (addr_q[1:0]),
        .sign_ext_i (sext_q),
        .wdata_i    (wdata_q),
        .rdata_i    (data_rdata_i),
        .be_o       (be_aligned),
        .wdata_o    (wdata_aligned),
        .rdata_o    (rdata_fmt)
    );

    // wd_q holds the number of wait-state cycles already spent, so the
    // watchdog fires during the RVALID_TIMEOUT-th wait cycle.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        type_d    = type_q;
        sext_d    = sext_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        wd_d      = wd_q;
        wd_expire = (RVALID_TIMEOUT != 0) && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                if (i_lsu_req) begin
                    we_d    = i_lsu_we;
                    type_d  = lsu_type_e'(i_lsu_type);
                    sext_d  = i_lsu_sign_ext;
                    addr_d  = i_lsu_addr;
                    wdata_d = i_lsu_wdata;
                    wd_d    = '0;
                    if (lsu_misaligned(lsu_type_e'(i_lsu_type), i_lsu_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                wd_d = wd_q + 1'b1;
                if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                wd_d = wd_q + 1'b1;
                // A real response wins over a watchdog expiring in the same cycle.
                if (data_rvalid_i) begin
                    err_d   = data_err_i;
                    state_d = RESP;
                    if (!we_q && !data_err_i) begin
                        rdata_d = rdata_fmt;
                    end
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            type_q  <= LSU_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
        end
    end

    // Bus attributes are only driven while a request is outstanding so that
    // the port is all-zero whenever the unit is not asking for the bus.
    always_comb begin
        o_lsu_busy   = (state_q != IDLE) || i_lsu_req;
        o_lsu_done   = (state_q == RESP);
        o_lsu_err    = (state_q == RESP) && err_q;
        o_lsu_rdata  = rdata_q;
        data_req_o   = (state_q == WAIT_GNT);
        data_we_o    = data_req_o & we_q;
        data_be_o    = data_req_o ? be_aligned : 4'b0000;
        data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
        data_wdata_o = data_req_o ? wdata_aligned : 32'h0;
    end

endmodule

// File: tb/tb_lsu_obi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_obi_ctrl
//  Directed bench for lsu_obi_ctrl. Each access is described by its bus timing
//  (grant delay, rvalid delay, error, timeout, abort); the bench turns that into
//  an expected cycle timeline and expected lane values, and a per-cycle compare
//  process checks the DUT against it. Literal checks pin the known examples.
// ----------------------------------------------------------------------------
module tb_lsu_obi_ctrl;

    localparam int TO  = 16;
    localparam int BIG = 1 << 30;

    logic        clk;
    logic        rst_n;
    logic        i_lsu_req;
    logic        i_lsu_we;
    logic [1:0]  i_lsu_type;
    logic        i_lsu_sign_ext;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic        o_lsu_err;
    logic [31:0] o_lsu_rdata;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit check_en = 0;

    // Expected timeline and values of the access in flight.
    int          t_acc    = 0;
    int          t_done   = -1;
    int          t_req_lo = 0;
    int          t_req_hi = -1;
    int          t_abort  = BIG;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we, e_err;
    logic [31:0] rd_old   = 32'h0;
    logic [31:0] rd_new   = 32'h0;
    bit          rd_upd   = 0;

    // Observations used by the literal checks.
    logic [3:0]  last_req_be;
    logic [31:0] last_req_wdata, last_req_addr;
    logic        last_req_we, last_done_err;
    int          last_done_cyc = 0;
    int          last_acc      = 0;
    int          req_cnt       = 0;
    int          done_cnt      = 0;

    lsu_obi_ctrl #(.RVALID_TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .i_lsu_req      (i_lsu_req),
        .i_lsu_we       (i_lsu_we),
        .i_lsu_type     (i_lsu_type),
        .i_lsu_sign_ext (i_lsu_sign_ext),
        .i_lsu_addr     (i_lsu_addr),
        .i_lsu_wdata    (i_lsu_wdata),
        .o_lsu_busy     (o_lsu_busy),
        .o_lsu_done     (o_lsu_done),
        .o_lsu_err      (o_lsu_err),
        .o_lsu_rdata    (o_lsu_rdata),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_err_i     (data_err_i),
        .data_rdata_i   (data_rdata_i),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sizeOf(input logic [1:0] typ);
        case (typ)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Pick size bytes starting at the offset, then extend.
    function automatic logic [31:0] fmtLoad(input logic [1:0] typ, input logic [1:0] off,
                                            input bit sext, input logic [31:0] rd);
        int          n;
        logic [31:0] v, mask;
        n    = sizeOf(typ);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (rd >> (8 * int'(off))) & mask;
        if (sext && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle compare of the DUT against the expected timeline.
    always @(negedge clk) begin
        if (check_en) begin
            int          t_end;
            bit          x_busy, x_req, x_done, zeroed;
            logic [31:0] x_rdata;
            zeroed  = (cyc >= t_abort);
            t_end   = (t_done < t_abort) ? t_done : t_abort - 1;
            x_busy  = (cyc >= t_acc) && (cyc <= t_end);
            x_req   = !zeroed && (cyc >= t_req_lo) && (cyc <= t_req_hi);
            x_done  = !zeroed && (cyc == t_done);
            x_rdata = zeroed ? 32'h0 : ((rd_upd && cyc >= t_done) ? rd_new : rd_old);
            checkOutput("busy",  {31'h0, o_lsu_busy}, {31'h0, x_busy});
            checkOutput("req",   {31'h0, data_req_o}, {31'h0, x_req});
            checkOutput("done",  {31'h0, o_lsu_done}, {31'h0, x_done});
            checkOutput("err",   {31'h0, o_lsu_err},  {31'h0, x_done & e_err});
            checkOutput("rdata", o_lsu_rdata, x_rdata);
            if (x_req) begin
                checkOutput("bus_addr",  data_addr_o,  e_addr);
                checkOutput("bus_be",    {28'h0, data_be_o}, {28'h0, e_be});
                checkOutput("bus_we",    {31'h0, data_we_o}, {31'h0, e_we});
                checkOutput("bus_wdata", data_wdata_o, e_wdata);
            end
            if (data_req_o) begin
                req_cnt++;
                last_req_be    = data_be_o;
                last_req_wdata = data_wdata_o;
                last_req_addr  = data_addr_o;
                last_req_we    = data_we_o;
            end
            if (o_lsu_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_done_err = o_lsu_err;
            end
        end
    end

    // Issues one access and plays the bus side with the given timing:
    // g = extra grant wait cycles, r = extra rvalid wait cycles after grant,
    // no_rv = never respond, spur = stray rvalid+err while waiting for grant,
    // abort_rel >= 0 pulls reset that many cycles after the accept.
    task automatic applyStimulus(input bit we, input logic [1:0] typ, input bit sext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int g, input int r, input logic [31:0] rdata,
                                 input bit derr, input bit no_rv, input bit spur,
                                 input int abort_rel);
        int         T, n, rv_cyc;
        bit         mis, fin;
        logic [1:0] off;
        T   = cyc;
        off = addr[1:0];
        n   = sizeOf(typ);
        mis = (n == 0) || (n == 2 && off[0]) || (n == 4 && off != 2'b00);

        e_addr  = {addr[31:2], 2'b00};
        e_we    = we;
        e_wdata = wdata << (8 * int'(off));
        for (int i = 0; i < 4; i++) e_be[i] = (i >= int'(off)) && (i < int'(off) + n);

        rv_cyc  = -5;
        rd_upd  = 0;
        rd_new  = fmtLoad(typ, off, sext, rdata);
        t_acc   = T;
        t_abort = (abort_rel >= 0) ? T + abort_rel : BIG;
        if (mis) begin
            t_req_lo = 0;
            t_req_hi = -1;
            t_done   = T + 1;
            e_err    = 1'b1;
        end else if (no_rv) begin
            t_req_lo = T + 1;
            t_req_hi = (g < TO) ? T + 1 + g : T + TO;
            t_done   = T + 1 + TO;
            e_err    = 1'b1;
        end else begin
            t_req_lo = T + 1;
            t_req_hi = T + 1 + g;
            rv_cyc   = T + 2 + g + r;
            t_done   = rv_cyc + 1;
            e_err    = derr;
            rd_upd   = !we && !derr;
        end

        i_lsu_req      = 1'b1;
        i_lsu_we       = we;
        i_lsu_type     = typ;
        i_lsu_sign_ext = sext;
        i_lsu_addr     = addr;
        i_lsu_wdata    = wdata;

        fin = 0;
        while (!fin) begin
            @(posedge clk);
            #1;
            if (cyc == T + 1) begin
                // Scramble the request fields so only the latched copy is valid.
                i_lsu_req      = 1'b0;
                i_lsu_we       = ~we;
                i_lsu_type     = ~typ;
                i_lsu_sign_ext = ~sext;
                i_lsu_addr     = ~addr;
                i_lsu_wdata    = ~wdata;
            end
            data_gnt_i    = !mis && (cyc == T + 1 + g) && (g < TO) && (cyc < t_abort);
            data_rvalid_i = (cyc == rv_cyc) || (spur && cyc == T + 1);
            data_err_i    = (cyc == rv_cyc) ? derr : (spur && cyc == T + 1);
            data_rdata_i  = (cyc == rv_cyc || (spur && cyc == T + 1)) ? rdata : 32'hA5A5_5A5A;
            if (cyc == t_abort)     rst_n = 1'b0;
            if (cyc == t_abort + 2) rst_n = 1'b1;
            fin = (abort_rel >= 0) ? (cyc == t_abort + 4) : (cyc == t_done + 1);
        end

        if (abort_rel >= 0) begin
            rd_old   = 32'h0;
            t_acc    = 0;
            t_done   = -1;
            t_req_hi = -1;
            t_abort  = BIG;
        end else if (rd_upd) begin
            rd_old = rd_new;
        end
        rd_upd   = 0;
        last_acc = T;
    endtask

    initial begin
        int req0, done0;
        rst_n          = 1'b0;
        i_lsu_req      = 1'b0;
        i_lsu_we       = 1'b0;
        i_lsu_type     = 2'b00;
        i_lsu_sign_ext = 1'b0;
        i_lsu_addr     = 32'h0;
        i_lsu_wdata    = 32'h0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_err_i     = 1'b0;
        data_rdata_i   = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",  {31'h0, o_lsu_busy}, 32'h0);
        checkOutput("rst_done",  {31'h0, o_lsu_done}, 32'h0);
        checkOutput("rst_err",   {31'h0, o_lsu_err},  32'h0);
        checkOutput("rst_rdata", o_lsu_rdata, 32'h0);
        checkOutput("rst_req",   {31'h0, data_req_o}, 32'h0);
        checkOutput("rst_be",    {28'h0, data_be_o},  32'h0);
        checkOutput("rst_addr",  data_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1;
        @(posedge clk);
        #1;

        $display("[TB] LW 0x100");
        applyStimulus(0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, 0, -1);
        checkOutput("lw_rdata",   o_lsu_rdata, 32'hDEADBEEF);
        checkOutput("lw_latency", 32'(last_done_cyc - last_acc), 32'd3);
        checkOutput("lw_be",      {28'h0, last_req_be}, 32'hF);
        checkOutput("lw_addr",    last_req_addr, 32'h100);
        checkOutput("lw_err",     {31'h0, last_done_err}, 32'h0);

        $display("[TB] LB/LBU 0x103");
        applyStimulus(0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF, 0, 0, 0, -1);
        checkOutput("lb_rdata", o_lsu_rdata, 32'hFFFF_FF80);
        checkOutput("lb_be",    {28'h0, last_req_be}, 32'h8);
        applyStimulus(0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF, 0, 0, 0, -1);
        checkOutput("lbu_rdata", o_lsu_rdata, 32'h0000_0080);

        $display("[TB] SH 0x102");
        applyStimulus(1, 2'b01, 0, 32'h102, 32'h1234, 0, 0, 32'h0, 0, 0, 0, -1);
        checkOutput("sh_be",    {28'h0, last_req_be}, 32'hC);
        checkOutput("sh_wdata", last_req_wdata, 32'h1234_0000);
        checkOutput("sh_we",    {31'h0, last_req_we}, 32'h1);
        checkOutput("sh_err",   {31'h0, last_done_err}, 32'h0);
        checkOutput("sh_rdata", o_lsu_rdata, 32'h0000_0080);

        $display("[TB] misaligned LW 0x101");
        req0 = req_cnt;
        applyStimulus(0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0, 0, 0, -1);
        checkOutput("mis_latency", 32'(last_done_cyc - last_acc), 32'd1);
        checkOutput("mis_no_req",  32'(req_cnt - req0), 32'd0);
        checkOutput("mis_err",     {31'h0, last_done_err}, 32'h1);

        $display("[TB] gnt withheld, bus error");
        req0 = req_cnt;
        applyStimulus(0, 2'b10, 0, 32'h104, 32'h0, 5, 1, 32'h1111_2222, 1, 0, 1, -1);
        checkOutput("gntwait_req_cycles", 32'(req_cnt - req0), 32'd6);
        checkOutput("buserr_err",   {31'h0, last_done_err}, 32'h1);
        checkOutput("buserr_rdata", o_lsu_rdata, 32'h0000_0080);

        $display("[TB] half/byte lanes");
        applyStimulus(0, 2'b01, 1, 32'h102, 32'h0, 0, 0, 32'h8001_1234, 0, 0, 0, -1);
        checkOutput("lh_rdata", o_lsu_rdata, 32'hFFFF_8001);
        applyStimulus(0, 2'b01, 0, 32'h100, 32'h0, 1, 2, 32'hFFFF_8002, 0, 0, 0, -1);
        checkOutput("lhu_rdata", o_lsu_rdata, 32'h0000_8002);
        applyStimulus(1, 2'b00, 0, 32'h101, 32'hAB, 0, 0, 32'h0, 0, 0, 0, -1);
        checkOutput("sb_be",    {28'h0, last_req_be}, 32'h2);
        checkOutput("sb_wdata", last_req_wdata, 32'h0000_AB00);
        applyStimulus(0, 2'b01, 1, 32'h103, 32'h0, 0, 0, 32'h0, 0, 0, 0, -1);
        applyStimulus(0, 2'b11, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0, 0, -1);
        checkOutput("rsvd_err", {31'h0, last_done_err}, 32'h1);

        $display("[TB] rvalid timeout");
        applyStimulus(0, 2'b10, 0, 32'h200, 32'h0, 0, 0, 32'h0, 0, 1, 0, -1);
        checkOutput("to_latency", 32'(last_done_cyc - last_acc), 32'd17);
        checkOutput("to_err",     {31'h0, last_done_err}, 32'h1);

        $display("[TB] reset during WAIT_RVALID");
        done0 = done_cnt;
        applyStimulus(0, 2'b10, 0, 32'h204, 32'h0, 0, 0, 32'h0, 0, 1, 0, 6);
        checkOutput("abort_no_done", 32'(done_cnt - done0), 32'd0);
        checkOutput("abort_rdata",   o_lsu_rdata, 32'h0);

        $display("[TB] recovery LW 0x300");
        applyStimulus(0, 2'b10, 0, 32'h300, 32'h0, 0, 0, 32'h1234_5678, 0, 0, 0, -1);
        checkOutput("recover_rdata", o_lsu_rdata, 32'h1234_5678);

        repeat (2) @(posedge clk);
        #1;
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
